pit_scheduler: RTL

PIT_SCHEDULER -- requirements
Module: pit_scheduler

---
 rtl/pit_scheduler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pit_scheduler.sv
// rtl/pit_scheduler.sv - round-robin arbiter that lends one programmable interval timer to four clients
// A granted client's 16-bit delay is loaded into the timer, armed, and run to expiry before the next grant.
module pit_scheduler #(
  parameter int ARM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_valid,
  input  logic [63:0] req_count,
  output logic [3:0]  req_ready,
  output logic [3:0]  done,
  output logic        done_err,
  output logic        busy,
  output logic [1:0]  active_id,
  output logic        pit_write_enable,
  output logic [7:0]  pit_counter_high,
  output logic [7:0]  pit_counter_low,
  output logic        pit_repeating,
  output logic        pit_divider_on,
  input  logic        pit_counter_set,
  input  logic        pit_interrupting
);

  localparam int AW = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_RUN, S_DONE} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [15:0]    count;
  logic [1:0]     last_grant;
  logic           err;
  logic [AW-1:0]  arm_cnt;
  logic           arm_expired;
  logic           grant_any;
  logic [1:0]     grant_id;
  logic [1:0]     idx;
  logic [15:0]    grant_count;

  // Search starts just past the previous owner so every client gets a turn.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = last_grant;
    idx       = last_grant;
    for (int k = 0; k < 4; k++) begin
      idx = last_grant + 2'(k + 1);
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
  end

  assign grant_count = req_count[{grant_id, 4'b0000} +: 16];
  assign arm_expired = (arm_cnt == AW'(ARM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    req_ready        = 4'b0000;
    done             = 4'b0000;
    done_err         = 1'b0;
    pit_write_enable = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_any) begin
          req_ready = 4'b0001 << grant_id;
          state_nxt = (grant_count == 16'd0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        pit_write_enable = 1'b1;
        state_nxt        = S_ARM;
      end
      S_ARM: begin
        if (pit_counter_set)  state_nxt = S_RUN;
        else if (arm_expired) state_nxt = S_DONE;
      end
      S_RUN: begin
        if (pit_interrupting) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 4'b0001 << active_id;
        done_err  = err;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // The grant path is combinational, so it must be silenced while reset is held.
    if (!rst_n) req_ready = 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= 16'd0;
      active_id  <= 2'd0;
      last_grant <= 2'd3;
      err        <= 1'b0;
      arm_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            count     <= grant_count;
            active_id <= grant_id;
          end
        end
        S_LOAD: arm_cnt <= '0;
        S_ARM: begin
          if (!pit_counter_set) begin
            if (arm_expired) err <= 1'b1;
            else             arm_cnt <= arm_cnt + AW'(1);
          end
        end
        S_DONE: begin
          last_grant <= active_id;
          err        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy             = (state != S_IDLE);
  assign pit_counter_high = count[15:8];
  assign pit_counter_low  = count[7:0];
  assign pit_repeating    = 1'b0;
  assign pit_divider_on   = 1'b0;

endmodule
